lcd_frame_buffer: RTL and testbench

Upstream feeder for the LCD character controller. Holds a 2x16 character image written by the E100 I/O path, one dirty bit per cell. Round-robin scans for dirty cells and drives the controller's lcd_command/lcd_response 4-phase handshake, one cell per transaction, so software never waits on the LCD.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_frame_buffer.sv | 119 +++++++++++
 tb/tb_lcd_frame_buffer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame buffer: geometry, scan FSM encoding and the
// default blank character.
package lcd_pkg;

   localparam int unsigned LCD_CELLS  = 32;
   localparam int unsigned LCD_COLS   = 16;
   localparam int unsigned LCD_ADDR_W = 5;

   localparam logic [7:0] LCD_BLANK_CHAR = 8'h20;

   typedef enum logic [1:0] {
      StScan = 2'd0,
      StReq  = 2'd1,
      StRel  = 2'd2
   } lcd_state_e;

endpackage

// File: rtl/lcd_frame_buffer.sv
// 2x16 character image with per-cell dirty bits; round-robin pushes dirty cells to the
// LCD controller over its 4-phase command/response handshake.
module lcd_frame_buffer
   import lcd_pkg::*;
#(
   parameter logic [7:0] BLANK_CHAR     = LCD_BLANK_CHAR,
   parameter logic       DIRTY_ON_RESET = 1'b1
) (
   input  logic                  clock_1_6m,
   input  logic                  reset_1_6m_n,
   input  logic                  clock_valid,
   input  logic                  wr_en,
   input  logic [LCD_ADDR_W-1:0] wr_addr,
   input  logic [7:0]            wr_data,
   input  logic                  clear,
   output logic                  lcd_command,
   input  logic                  lcd_response,
   output logic [3:0]            lcd_x,
   output logic                  lcd_y,
   output logic [7:0]            lcd_ascii,
   output logic                  synced
);

   logic [7:0]            cell_q [LCD_CELLS];
   logic [7:0]            cell_d [LCD_CELLS];
   logic [LCD_CELLS-1:0]  dirty_q, dirty_d;
   logic [LCD_ADDR_W-1:0] ptr_q, ptr_d;
   lcd_state_e            state_q, state_d;
   logic                  command_q, command_d;
   logic [3:0]            x_q, x_d;
   logic                  y_q, y_d;
   logic [7:0]            ascii_q, ascii_d;
   logic                  synced_q, synced_d;

   always_comb begin
      cell_d    = cell_q;
      dirty_d   = dirty_q;
      ptr_d     = ptr_q;
      state_d   = state_q;
      command_d = command_q;
      x_d       = x_q;
      y_d       = y_q;
      ascii_d   = ascii_q;

      unique case (state_q)
         StScan: begin
            if (dirty_q[ptr_q]) begin
               // A stale acknowledge after reset must drain before the next launch.
               if (!lcd_response) begin
                  y_d            = ptr_q[LCD_ADDR_W-1];
                  x_d            = ptr_q[LCD_ADDR_W-2:0];
                  ascii_d        = cell_q[ptr_q];
                  dirty_d[ptr_q] = 1'b0;
                  command_d      = 1'b1;
                  state_d        = StReq;
               end
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         StReq: begin
            if (lcd_response) begin
               command_d = 1'b0;
               state_d   = StRel;
            end
         end
         StRel: begin
            if (!lcd_response) begin
               ptr_d   = ptr_q + 1'b1;
               state_d = StScan;
            end
         end
         default: state_d = StScan;
      endcase

      // Sets come after the launch clear so a same-cycle write keeps the cell dirty.
      if (clear) begin
         for (int i = 0; i < LCD_CELLS; i++) cell_d[i] = BLANK_CHAR;
         dirty_d = '1;
      end
      if (wr_en) begin
         cell_d[wr_addr]  = wr_data;
         dirty_d[wr_addr] = 1'b1;
      end

      synced_d = (dirty_d == '0) && (state_d == StScan);
   end

   always_ff @(posedge clock_1_6m or negedge reset_1_6m_n) begin
      if (!reset_1_6m_n) begin
         for (int i = 0; i < LCD_CELLS; i++) cell_q[i] <= BLANK_CHAR;
         dirty_q   <= {LCD_CELLS{DIRTY_ON_RESET}};
         ptr_q     <= '0;
         state_q   <= StScan;
         command_q <= 1'b0;
         x_q       <= '0;
         y_q       <= 1'b0;
         ascii_q   <= BLANK_CHAR;
         synced_q  <= 1'b0;
      end else if (clock_valid) begin
         cell_q    <= cell_d;
         dirty_q   <= dirty_d;
         ptr_q     <= ptr_d;
         state_q   <= state_d;
         command_q <= command_d;
         x_q       <= x_d;
         y_q       <= y_d;
         ascii_q   <= ascii_d;
         synced_q  <= synced_d;
      end
   end

   assign lcd_command = command_q;
   assign lcd_x       = x_q;
   assign lcd_y       = y_q;
   assign lcd_ascii   = ascii_q;
   assign synced      = synced_q;

endmodule

// File: tb/tb_lcd_frame_buffer.sv
// Self-checking bench for lcd_frame_buffer: a delayed-ack responder model, a transaction
// monitor, a table of single-cell writes and directed multi-cycle corner cases.
`timescale 1ns / 1ps
module tb_lcd_frame_buffer;

   logic       clock_1_6m;
   logic       reset_1_6m_n;
   logic       clock_valid;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       clear;
   logic       lcd_command;
   logic       lcd_response;
   logic [3:0] lcd_x;
   logic       lcd_y;
   logic [7:0] lcd_ascii;
   logic       synced;

   lcd_frame_buffer dut (
      .clock_1_6m   (clock_1_6m),
      .reset_1_6m_n (reset_1_6m_n),
      .clock_valid  (clock_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .clear        (clear),
      .lcd_command  (lcd_command),
      .lcd_response (lcd_response),
      .lcd_x        (lcd_x),
      .lcd_y        (lcd_y),
      .lcd_ascii    (lcd_ascii),
      .synced       (synced)
   );

   initial clock_1_6m = 1'b0;
   always #320 clock_1_6m = ~clock_1_6m;

   typedef struct packed {
      logic       y;
      logic [3:0] x;
      logic [7:0] ascii;
   } txn_t;

   typedef struct {
      logic [4:0] addr;
      logic [7:0] data;
      logic       exp_y;
      logic [3:0] exp_x;
      logic [7:0] exp_ascii;
   } wr_vec_t;

   txn_t    txns[$];
   txn_t    cur;
   wr_vec_t vecs[5];
   int      checks = 0;
   int      errors = 0;
   int      stab_err = 0;
   int      resp_delay = 3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Responder: acks resp_delay cycles after a command, releases once the command drops.
   initial begin
      int cnt;
      cnt = 0;
      lcd_response = 1'b0;
      forever begin
         @(negedge clock_1_6m);
         if (!lcd_command) begin
            cnt = 0;
            lcd_response = 1'b0;
         end else if (!lcd_response) begin
            cnt++;
            if (cnt >= resp_delay) lcd_response = 1'b1;
         end
      end
   end

   // Monitor: logs each launch and flags payload changes while the command is held.
   initial begin
      logic cmd_prev;
      cmd_prev = 1'b0;
      cur = '0;
      forever begin
         @(negedge clock_1_6m);
         if (lcd_command && !cmd_prev) begin
            if (lcd_response) stab_err++;
            cur = '{y: lcd_y, x: lcd_x, ascii: lcd_ascii};
            txns.push_back(cur);
         end else if (lcd_command && cmd_prev) begin
            if ({lcd_y, lcd_x, lcd_ascii} != cur) stab_err++;
         end
         cmd_prev = lcd_command;
      end
   end

   task automatic wait_synced(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clock_1_6m);
         n++;
      end while (!synced && n < budget);
      check(name, 32'(synced), 32'd1);
   endtask

   task automatic wait_cmd(input string name, input int budget);
      int n;
      n = 0;
      while (!lcd_command && n < budget) begin
         @(negedge clock_1_6m);
         n++;
      end
      check(name, 32'(lcd_command), 32'd1);
   endtask

   task automatic write_cell(input logic [4:0] addr, input logic [7:0] data);
      @(negedge clock_1_6m);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      @(negedge clock_1_6m);
      wr_en   = 1'b0;
   endtask

   task automatic check_full_repaint(input string name, input logic [7:0] ascii);
      check({name, "_count"}, 32'(txns.size()), 32'd32);
      for (int i = 0; i < txns.size() && i < 32; i++) begin
         check({name, "_addr"}, {27'd0, txns[i].y, txns[i].x}, 32'(i));
         check({name, "_ascii"}, 32'(txns[i].ascii), 32'(ascii));
      end
   endtask

   initial begin
      logic [31:0] seen;
      int          hold;
      int          high_cnt;

      vecs[0] = '{addr: 5'h13, data: 8'h41, exp_y: 1'b1, exp_x: 4'h3, exp_ascii: 8'h41};
      vecs[1] = '{addr: 5'h00, data: 8'h61, exp_y: 1'b0, exp_x: 4'h0, exp_ascii: 8'h61};
      vecs[2] = '{addr: 5'h1f, data: 8'h7e, exp_y: 1'b1, exp_x: 4'hf, exp_ascii: 8'h7e};
      vecs[3] = '{addr: 5'h0f, data: 8'h30, exp_y: 1'b0, exp_x: 4'hf, exp_ascii: 8'h30};
      vecs[4] = '{addr: 5'h10, data: 8'h5a, exp_y: 1'b1, exp_x: 4'h0, exp_ascii: 8'h5a};

      reset_1_6m_n = 1'b0;
      clock_valid  = 1'b1;
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      clear        = 1'b0;

      // Reset state and power-up repaint.
      repeat (3) @(negedge clock_1_6m);
      check("rst_command", 32'(lcd_command), 32'd0);
      check("rst_x", 32'(lcd_x), 32'd0);
      check("rst_y", 32'(lcd_y), 32'd0);
      check("rst_ascii", 32'(lcd_ascii), 32'h20);
      check("rst_synced", 32'(synced), 32'd0);
      txns.delete();
      reset_1_6m_n = 1'b1;
      wait_synced("powerup_sync", 3000);
      check_full_repaint("powerup", 8'h20);

      // Single-cell writes after sync.
      for (int v = 0; v < 5; v++) begin
         txns.delete();
         write_cell(vecs[v].addr, vecs[v].data);
         wait_synced("vec_sync", 200);
         check("vec_count", 32'(txns.size()), 32'd1);
         if (txns.size() > 0) begin
            check("vec_y", 32'(txns[0].y), 32'(vecs[v].exp_y));
            check("vec_x", 32'(txns[0].x), 32'(vecs[v].exp_x));
            check("vec_ascii", 32'(txns[0].ascii), 32'(vecs[v].exp_ascii));
         end
      end

      // Write to the in-flight cell: snapshot goes out, new value follows on a later pass.
      resp_delay = 20;
      txns.delete();
      write_cell(5'h02, 8'h20);
      wait_cmd("inflight_cmd", 100);
      check("inflight_x", 32'(lcd_x), 32'd2);
      write_cell(5'h02, 8'h42);
      wait_synced("inflight_sync", 500);
      check("inflight_count", 32'(txns.size()), 32'd2);
      if (txns.size() >= 2) begin
         check("inflight_first", 32'(txns[0]), 32'({1'b0, 4'h2, 8'h20}));
         check("inflight_second", 32'(txns[1]), 32'({1'b0, 4'h2, 8'h42}));
      end

      // Clear with a same-cycle write to cell 0.
      resp_delay = 3;
      txns.delete();
      @(negedge clock_1_6m);
      clear   = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 5'h00;
      wr_data = 8'h58;
      @(negedge clock_1_6m);
      clear   = 1'b0;
      wr_en   = 1'b0;
      wait_synced("clear_sync", 3000);
      check("clear_count", 32'(txns.size()), 32'd32);
      seen = '0;
      foreach (txns[i]) begin
         seen[{txns[i].y, txns[i].x}] = 1'b1;
         check("clear_ascii", 32'(txns[i].ascii),
               ({txns[i].y, txns[i].x} == 5'd0) ? 32'h58 : 32'h20);
      end
      check("clear_cells", seen, 32'hffff_ffff);

      // Slow acknowledge: command and payload hold for the whole wait.
      resp_delay = 1000;
      txns.delete();
      write_cell(5'h07, 8'h37);
      wait_cmd("slow_cmd", 100);
      hold = 0;
      while (lcd_command && hold < 1100) begin
         @(negedge clock_1_6m);
         if (lcd_command) hold++;
      end
      check("slow_hold", 32'(hold >= 995), 32'd1);
      wait_synced("slow_sync", 200);
      check("slow_count", 32'(txns.size()), 32'd1);
      if (txns.size() > 0) check("slow_txn", 32'(txns[0]), 32'({1'b0, 4'h7, 8'h37}));

      // clock_valid low: FSM frozen in REQ, writes ignored.
      resp_delay = 3;
      txns.delete();
      write_cell(5'h04, 8'h34);
      wait_cmd("freeze_cmd", 100);
      clock_valid = 1'b0;
      wr_en       = 1'b1;
      wr_addr     = 5'h0c;
      wr_data     = 8'h43;
      high_cnt    = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock_1_6m);
         wr_en = 1'b0;
         if (lcd_command && lcd_x == 4'h4) high_cnt++;
      end
      check("freeze_hold", 32'(high_cnt), 32'd10);
      clock_valid = 1'b1;
      wait_synced("freeze_sync", 200);
      check("freeze_count", 32'(txns.size()), 32'd1);
      if (txns.size() > 0) check("freeze_txn", 32'(txns[0]), 32'({1'b0, 4'h4, 8'h34}));

      // Reset during REQ: command drops asynchronously, then a full blank repaint.
      resp_delay = 50;
      write_cell(5'h09, 8'h39);
      wait_cmd("midrst_cmd", 100);
      #100;
      reset_1_6m_n = 1'b0;
      #1;
      check("midrst_command", 32'(lcd_command), 32'd0);
      @(negedge clock_1_6m);
      resp_delay   = 3;
      txns.delete();
      reset_1_6m_n = 1'b1;
      wait_synced("midrst_sync", 3000);
      check_full_repaint("midrst", 8'h20);

      check("payload_stable", 32'(stab_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
